// File: rtl/sram_arb_ctrl.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency SRAM among NUM_PORTS
// requesters. It can zero-fill the array after reset and routes read data back to its owner.
//
// state   | meaning
// ST_INIT | sweeping the array with zero writes, no grants
// ST_RUN  | arbitrating requesters onto the SRAM
module sram_arb_ctrl #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024,
  parameter int INIT_ZERO  = 1,
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*AW-1:0]         addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*BW-1:0]         be_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            init_done_o,
  output logic                            sram_req_o,
  output logic                            sram_we_o,
  output logic [AW-1:0]                   sram_addr_o,
  output logic [DATA_WIDTH-1:0]           sram_wdata_o,
  output logic [BW-1:0]                   sram_be_o,
  input  logic [DATA_WIDTH-1:0]           sram_rdata_i
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        win;
  logic                 found;
  logic [NUM_PORTS-1:0] gnt_d;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic                 init_done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rvalid_q    <= '0;
      init_done_q <= (INIT_ZERO == 0);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rvalid_q    <= gnt_d & ~we_i;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    int idx;
    found        = 1'b0;
    win          = '0;
    gnt_d        = '0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;

    // First requester at or after the pointer, wrapping modulo NUM_PORTS.
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end

    // Outputs are forced quiet while reset is held, whatever the state register holds.
    if (!rst_i) begin
      case (state_q)
        ST_INIT: begin
          sram_req_o  = 1'b1;
          sram_we_o   = 1'b1;
          sram_be_o   = '1;
          sram_addr_o = cnt_q;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == AW'(NUM_WORDS - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (found) begin
            gnt_d[win]   = 1'b1;
            sram_req_o   = 1'b1;
            sram_we_o    = we_i[win];
            sram_addr_o  = addr_i[int'(win)*AW +: AW];
            sram_wdata_o = wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            sram_be_o    = be_i[int'(win)*BW +: BW];
            ptr_d        = (int'(win) == NUM_PORTS - 1) ? '0 : PW'(int'(win) + 1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign gnt_o       = gnt_d;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = sram_rdata_i;
  assign init_done_o = init_done_q;

endmodule
